// File: rtl/evenodd_pkg.sv
// Shared types and constants for the even/odd stream classifier.
package evenodd_pkg;

    typedef enum logic [1:0] {
        EO_IDLE = 2'd0,
        EO_EVEN = 2'd1,
        EO_ODD  = 2'd2
    } eo_state_t;

    localparam logic EO_MODE_NUM = 1'b0;  // classify by data_in[0]
    localparam logic EO_MODE_BIT = 1'b1;  // classify by XOR of all bits

endpackage

// File: rtl/eo_sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
module eo_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         load1,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= W'(1);
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/evenodd_classifier.sv
// Streaming even/odd classifier with per-class totals and same-class run length.
module evenodd_classifier
    import evenodd_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 16,
    parameter int RUN_W     = 8,
    parameter int STREAK_TH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             mode,
    input  logic             clear,
    output logic             even,
    output logic             odd,
    output logic             out_valid,
    output logic [CNT_W-1:0] even_cnt,
    output logic [CNT_W-1:0] odd_cnt,
    output logic [RUN_W-1:0] run_len,
    output logic             streak
);

    eo_state_t state;
    eo_state_t sample_state;
    logic      sample_odd;
    logic      accept;
    logic      same_class;

    assign sample_odd   = (mode == EO_MODE_BIT) ? ^data_in : data_in[0];
    assign sample_state = sample_odd ? EO_ODD : EO_EVEN;
    assign accept       = in_valid && !clear;
    // From IDLE this is never true, so the first sample after reset/clear reloads run_len to 1.
    assign same_class   = (state == sample_state);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EO_IDLE;
            out_valid <= 1'b0;
        end else if (clear) begin
            state     <= EO_IDLE;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                state <= sample_state;
            end
        end
    end

    eo_sat_counter #(.W(CNT_W)) u_even_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (accept && !sample_odd),
        .load1   (1'b0),
        .clr     (clear),
        .cnt     (even_cnt)
    );

    eo_sat_counter #(.W(CNT_W)) u_odd_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (accept && sample_odd),
        .load1   (1'b0),
        .clr     (clear),
        .cnt     (odd_cnt)
    );

    eo_sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (accept && same_class),
        .load1   (accept && !same_class),
        .clr     (clear),
        .cnt     (run_len)
    );

    assign even   = (state == EO_EVEN);
    assign odd    = (state == EO_ODD);
    assign streak = (run_len >= RUN_W'(STREAK_TH));

endmodule
